// File: rtl/shift_operand_stage_pkg.sv
// Shared widths, shift codes, FSM states and the shifter operand bundle.
package shift_operand_stage_pkg;

  localparam int unsigned FULLW         = 32;
  localparam int unsigned WIDTH         = 5;
  localparam int unsigned SHIFTCODEW    = 2;
  localparam int unsigned INSTRW        = 32;
  localparam int unsigned RSADDRW       = 4;
  localparam int unsigned AMTW          = 8;
  localparam int unsigned OP2_IMM_BIT   = 25;
  localparam int unsigned OP2_REGSH_BIT = 4;

  typedef enum logic [SHIFTCODEW-1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shiftcode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RS_WAIT = 1'b1
  } state_e;

  // Everything the shifter and the ALU override mux need for one operand.
  typedef struct packed {
    logic [FULLW-1:0] shiftin;
    logic [WIDTH-1:0] shiftby;
    shiftcode_e       shiftcode;
    logic             fix_en;
    logic [FULLW-1:0] fix_val;
    logic             fix_carry;
  } op2_t;

endpackage

// File: rtl/shift_operand_stage_reg_shift_amount_map.sv
// Maps an 8-bit register shift amount onto the shifter's 5-bit encoding,
// falling back to a fixed result/carry where that encoding cannot express it.
module reg_shift_amount_map
  import shift_operand_stage_pkg::*;
(
  input  shiftcode_e       code_i,
  input  logic [AMTW-1:0]  amt_i,
  input  logic [FULLW-1:0] rm_i,
  output op2_t             op2_c_o
);

  logic amt_ge32;
  logic amt_is32;
  logic lo5_zero;

  assign amt_ge32 = |amt_i[AMTW-1:WIDTH];
  assign amt_is32 = (amt_i == AMTW'(32));
  assign lo5_zero = (amt_i[WIDTH-1:0] == '0);

  // Amount classification: 0, 1..31 pass straight through; >=32 needs care.
  always_comb begin
    op2_c_o           = '0;
    op2_c_o.shiftin   = rm_i;
    op2_c_o.shiftcode = code_i;
    op2_c_o.shiftby   = amt_i[WIDTH-1:0];
    if (amt_i == '0) begin
      // Zero register amount leaves Rm and the carry flag untouched.
      op2_c_o.shiftcode = SH_LSL;
      op2_c_o.shiftby   = '0;
    end else if (amt_ge32) begin
      case (code_i)
        SH_LSL: begin
          op2_c_o.shiftby   = '0;
          op2_c_o.fix_en    = 1'b1;
          op2_c_o.fix_val   = '0;
          op2_c_o.fix_carry = amt_is32 ? rm_i[0] : 1'b0;
        end
        SH_LSR: begin
          // LSR #0 in the shifter already means LSR #32.
          op2_c_o.shiftby = '0;
          if (!amt_is32) begin
            op2_c_o.fix_en    = 1'b1;
            op2_c_o.fix_val   = '0;
            op2_c_o.fix_carry = 1'b0;
          end
        end
        SH_ASR: begin
          // ASR #0 in the shifter means ASR #32, identical for all larger amounts.
          op2_c_o.shiftby = '0;
        end
        default: begin
          // Rotations by a multiple of 32 return Rm with carry = Rm[31].
          if (lo5_zero) begin
            op2_c_o.fix_en    = 1'b1;
            op2_c_o.fix_val   = rm_i;
            op2_c_o.fix_carry = rm_i[FULLW-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// Operand2 decode stage feeding shifter32: immediate, immediate-shift and
// register-shift forms, with a one-cycle Rs fetch for the register form.
module shift_operand_stage
  import shift_operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTRW-1:0]     in_instr,
  input  logic [FULLW-1:0]      in_rm_data,
  output logic                  rs_rd_en,
  output logic [RSADDRW-1:0]    rs_addr,
  input  logic [FULLW-1:0]      rs_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULLW-1:0]      out_shiftin,
  output logic [WIDTH-1:0]      out_shiftby,
  output logic [SHIFTCODEW-1:0] out_shiftcode,
  output logic                  out_fix_en,
  output logic [FULLW-1:0]      out_fix_val,
  output logic                  out_fix_carry
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  op2_t             out_q, out_d;
  logic [FULLW-1:0] rm_q, rm_d;
  shiftcode_e       code_q, code_d;

  logic             is_imm;
  logic             is_regsh;
  logic             accept;
  op2_t             imm_op2;
  op2_t             rs_op2;
  logic [3:0]       rot;
  logic             unused_bits;

  assign unused_bits = ^{in_instr[INSTRW-1:OP2_IMM_BIT+1], in_instr[OP2_IMM_BIT-1:12],
                         rs_data[FULLW-1:AMTW]};

  assign is_imm   = in_instr[OP2_IMM_BIT];
  assign is_regsh = !is_imm && in_instr[OP2_REGSH_BIT];
  assign rot      = in_instr[11:8];
  assign in_ready = !flush && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign rs_addr  = in_instr[11:8];

  // Decode of the two forms that complete in the accept cycle.
  always_comb begin
    imm_op2 = '0;
    if (is_imm) begin
      imm_op2.shiftin = FULLW'(in_instr[7:0]);
      if (rot == '0) begin
        // ROR #0 would be RRX in the shifter, so an unrotated immediate uses LSL #0.
        imm_op2.shiftcode = SH_LSL;
        imm_op2.shiftby   = '0;
      end else begin
        imm_op2.shiftcode = SH_ROR;
        imm_op2.shiftby   = {rot, 1'b0};
      end
    end else begin
      imm_op2.shiftin   = in_rm_data;
      imm_op2.shiftcode = shiftcode_e'(in_instr[6:5]);
      imm_op2.shiftby   = in_instr[11:7];
    end
  end

  reg_shift_amount_map u_amount_map (
    .code_i  (code_q),
    .amt_i   (rs_data[AMTW-1:0]),
    .rm_i    (rm_q),
    .op2_c_o (rs_op2)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: register shifts spend exactly one cycle waiting for Rs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && is_regsh) state_d = ST_RS_WAIT;
      ST_RS_WAIT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: Rs read strobe only on the accept cycle of a register shift.
  always_comb begin
    rs_rd_en = 1'b0;
    if ((state_q == ST_IDLE) && accept && is_regsh) rs_rd_en = 1'b1;
  end

  // Output register / Rm latch next-state; flush wins over every load.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_d       = out_q;
    rm_d        = rm_q;
    code_d      = code_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (state_q == ST_RS_WAIT) begin
      out_valid_d = 1'b1;
      out_d       = rs_op2;
    end else if (accept) begin
      if (is_regsh) begin
        rm_d   = in_rm_data;
        code_d = shiftcode_e'(in_instr[6:5]);
      end else begin
        out_valid_d = 1'b1;
        out_d       = imm_op2;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rm_q        <= '0;
      code_q      <= SH_LSL;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rm_q        <= rm_d;
      code_q      <= code_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_shiftin   = out_q.shiftin;
  assign out_shiftby   = out_q.shiftby;
  assign out_shiftcode = out_q.shiftcode;
  assign out_fix_en    = out_q.fix_en;
  assign out_fix_val   = out_q.fix_val;
  assign out_fix_carry = out_q.fix_carry;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Bench for shift_operand_stage: directed cases plus random traffic checked
// against an architectural operand2 (value, carry) model.
module tb_shift_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rm_data = '0;
  logic        rs_rd_en;
  logic [3:0]  rs_addr;
  logic [31:0] rs_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_shiftin;
  logic [4:0]  out_shiftby;
  logic [1:0]  out_shiftcode;
  logic        out_fix_en;
  logic [31:0] out_fix_val;
  logic        out_fix_carry;

  always #5 clk = ~clk;

  shift_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_rm_data(in_rm_data),
    .rs_rd_en(rs_rd_en), .rs_addr(rs_addr), .rs_data(rs_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_shiftin(out_shiftin), .out_shiftby(out_shiftby), .out_shiftcode(out_shiftcode),
    .out_fix_en(out_fix_en), .out_fix_val(out_fix_val), .out_fix_carry(out_fix_carry)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rm;
    logic [31:0] rs;
    int          acc_cyc;
  } txn_t;

  txn_t        expq[$];
  logic [31:0] rf[16];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rdy_mode = 1;
  int          n_regsh = 0;
  int          rs_pulses = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: ARM operand2 value and carry ----------------
  function automatic logic [31:0] rot_r(input logic [31:0] v, input int r);
    int k;
    k = r % 32;
    if (k == 0) return v;
    return (v >> k) | (v << (32 - k));
  endfunction

  // Immediate-count shift (also what shifter32 computes from shiftin/shiftby/shiftcode).
  function automatic logic [32:0] imm_shift(input logic [31:0] v, input logic [1:0] code,
                                            input int amt, input logic c);
    logic [63:0] w;
    case (code)
      2'd0: begin
        if (amt == 0) return {v, c};
        w = {32'b0, v} << amt;
        return {w[31:0], w[32]};
      end
      2'd1: begin
        if (amt == 0) return {32'b0, v[31]};
        return {v >> amt, v[amt-1]};
      end
      2'd2: begin
        if (amt == 0) return {{32{v[31]}}, v[31]};
        return {32'($signed(v) >>> amt), v[amt-1]};
      end
      default: begin
        if (amt == 0) return {c, v[31:1], v[0]};
        return {rot_r(v, amt), v[amt-1]};
      end
    endcase
  endfunction

  // Shift by the bottom byte of a register.
  function automatic logic [32:0] reg_shift(input logic [31:0] v, input logic [1:0] code,
                                            input int s, input logic c);
    if (s == 0) return {v, c};
    case (code)
      2'd0: begin
        if (s < 32) return imm_shift(v, 2'd0, s, c);
        if (s == 32) return {32'b0, v[0]};
        return 33'b0;
      end
      2'd1: begin
        if (s < 32) return imm_shift(v, 2'd1, s, c);
        if (s == 32) return {32'b0, v[31]};
        return 33'b0;
      end
      2'd2: begin
        if (s < 32) return imm_shift(v, 2'd2, s, c);
        return {{32{v[31]}}, v[31]};
      end
      default: begin
        if (s % 32 == 0) return {v, v[31]};
        return imm_shift(v, 2'd3, s % 32, c);
      end
    endcase
  endfunction

  function automatic logic [32:0] arm_op2(input txn_t t, input logic c);
    logic [31:0] val;
    int r;
    if (t.instr[25]) begin
      r   = 2 * int'(t.instr[11:8]);
      val = rot_r({24'b0, t.instr[7:0]}, r);
      return {val, (r == 0) ? c : val[31]};
    end
    if (!t.instr[4]) return imm_shift(t.rm, t.instr[6:5], int'(t.instr[11:7]), c);
    return reg_shift(t.rm, t.instr[6:5], int'(t.rs[7:0]), c);
  endfunction

  // What the ALU ends up with given the stage outputs and a carry-in.
  function automatic logic [32:0] dut_op2(input logic c);
    if (out_fix_en) return {out_fix_val, out_fix_carry};
    return imm_shift(out_shiftin, out_shiftcode, int'(out_shiftby), c);
  endfunction

  function automatic logic [72:0] dut_fields();
    return {out_shiftin, out_shiftby, out_shiftcode, out_fix_en, out_fix_val, out_fix_carry};
  endfunction

  // ---------------- environment ----------------
  always @(posedge clk) cyc <= cyc + 1;

  // Register file read port B: data one cycle after the strobe, junk otherwise.
  initial begin
    forever begin
      @(posedge clk);
      rs_data <= rs_rd_en ? rf[rs_addr] : $urandom();
    end
  end

  // Downstream ready: 0 = stall, 1 = always ready, otherwise random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: latency, hold stability, in-order result check, Rs strobe context.
  initial begin
    logic        prev_hold;
    logic [72:0] prev_fields;
    txn_t        t;
    int          lat;
    prev_hold   = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        prev_hold = 1'b0;
      end else begin
        if (rs_rd_en) begin
          rs_pulses++;
          chk("rs_addr", rs_addr, in_instr[11:8]);
          chk("rs_rd_ctx", {in_valid, !in_instr[25] && in_instr[4]}, 2'b11);
        end
        if (out_valid) begin
          if (expq.size() == 0) begin
            chk("spurious_out", out_valid, 1'b0);
          end else begin
            if (prev_hold) begin
              chk("hold_stable", dut_fields(), prev_fields);
            end else begin
              lat = (!expq[0].instr[25] && expq[0].instr[4]) ? 1 : 0;
              chk("latency", cyc, expq[0].acc_cyc + lat);
            end
            if (out_ready) begin
              t = expq.pop_front();
              chk("op2_result", {dut_op2(1'b0), dut_op2(1'b1)},
                  {arm_op2(t, 1'b0), arm_op2(t, 1'b1)});
            end
          end
        end
        prev_hold   = out_valid && !out_ready;
        prev_fields = dut_fields();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present(input logic [31:0] instr, input logic [31:0] rm);
    @(posedge clk);
    #1;
    in_instr   = instr;
    in_rm_data = rm;
    in_valid   = 1'b1;
  endtask

  task automatic await_accept();
    txn_t t;
    bit   done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        t.instr   = in_instr;
        t.rm      = in_rm_data;
        t.rs      = rf[in_instr[11:8]];
        t.acc_cyc = cyc + 1;
        expq.push_back(t);
        if (!in_instr[25] && in_instr[4]) n_regsh++;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] rm);
    present(instr, rm);
    await_accept();
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) chk("valid_timeout", out_valid, 1'b1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && expq.size() != 0; k++) @(negedge clk);
    chk("drain_left", expq.size(), 0);
  endtask

  function automatic logic [31:0] rand_rs();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return $urandom_range(1, 31);
      2:       return 32'd32;
      3:       return $urandom_range(33, 255);
      4:       return 32'h100 * $urandom_range(1, 8);
      5:       return 32'h40 | ($urandom() & 32'hFFFF_FF00);
      6:       return 32'd32 * $urandom_range(1, 7);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] instr;
    logic [31:0] rm;
    for (int i = 0; i < 16; i++) rf[i] = $urandom();

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("reset_valid", {out_valid, rs_rd_en}, 2'b00);
    chk("reset_fields", dut_fields(), 73'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: rotated immediate, rot=4 imm8=0xFF.
    send(32'hE200_04FF, $urandom());
    wait_valid();
    chk("t1_fields", {out_shiftin, out_shiftby, out_shiftcode, out_fix_en},
        {32'hFF, 5'd8, 2'd3, 1'b0});

    // 2: unrotated immediate and imm-shift LSR #0.
    send(32'hE200_005A, $urandom());
    wait_valid();
    chk("t2_imm_rot0", {out_shiftin, out_shiftby, out_shiftcode, out_fix_en},
        {32'h5A, 5'd0, 2'd0, 1'b0});
    send(32'hE1A0_0023, 32'h1234_5678);
    wait_valid();
    chk("t2_lsr0", {out_shiftin, out_shiftby, out_shiftcode, out_fix_en},
        {32'h1234_5678, 5'd0, 2'd1, 1'b0});

    // 3: LSL by register, 32 and 33.
    rf[3] = 32'h20;
    send(32'hE1A0_0310, 32'h8000_0001);
    wait_valid();
    chk("t3_lsl32", {out_fix_en, out_fix_val, out_fix_carry}, {1'b1, 32'h0, 1'b1});
    rf[3] = 32'h21;
    send(32'hE1A0_0310, 32'h8000_0001);
    wait_valid();
    chk("t3_lsl33", {out_fix_en, out_fix_val, out_fix_carry}, {1'b1, 32'h0, 1'b0});

    // 4: ROR by register: 64, 256 (bottom byte 0) and 5.
    rf[3] = 32'h40;
    send(32'hE1A0_0370, 32'h8000_0000);
    wait_valid();
    chk("t4_ror64", {out_fix_en, out_fix_val, out_fix_carry}, {1'b1, 32'h8000_0000, 1'b1});
    rf[3] = 32'h100;
    send(32'hE1A0_0370, 32'h8000_0000);
    wait_valid();
    chk("t4_ror256", {out_fix_en, out_shiftcode, out_shiftby}, {1'b0, 2'd0, 5'd0});
    rf[3] = 32'h05;
    send(32'hE1A0_0370, 32'h8000_0000);
    wait_valid();
    chk("t4_ror5", {out_fix_en, out_shiftcode, out_shiftby}, {1'b0, 2'd3, 5'd5});

    // 5: back-pressure with two immediates queued.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    send(32'hE200_0111, $urandom());
    present(32'hE200_02AB, $urandom());
    repeat (3) begin
      @(negedge clk);
      chk("t5_in_ready", in_ready, 1'b0);
      chk("t5_hold", {out_valid, out_shiftin}, {1'b1, 32'h11});
    end
    rdy_mode = 1;
    await_accept();
    wait_drain();

    // 6a: flush while waiting for Rs.
    rf[5] = 32'h7;
    send(32'hE1A0_0510, $urandom());
    flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_strobe", {rs_rd_en, in_ready}, 2'b00);
    @(posedge clk);
    #1;
    flush = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("t6_flush_kill", out_valid, 1'b0);
    chk("t6_ready_after", in_ready, 1'b1);
    send(32'hE200_00C3, $urandom());
    wait_drain();

    // 6b: flush held against a presented register shift suppresses the Rs read.
    present(32'hE1A0_0550, 32'hF000_000F);
    flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_rsrd", {rs_rd_en, in_ready}, 2'b00);
    @(posedge clk);
    #1;
    flush = 1'b0;
    await_accept();
    wait_drain();

    // 6c: asynchronous reset with a held output.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    send(32'hE200_0F77, $urandom());
    wait_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", out_valid, 1'b0);
    chk("t6_rst_fields", dut_fields(), 73'b0);
    expq.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 2;

    // Random traffic across all three forms.
    for (int n = 0; n < 400; n++) begin
      instr = $urandom();
      rm    = ($urandom_range(0, 4) == 0) ? 32'h8000_0001 : $urandom();
      case ($urandom_range(0, 2))
        0: instr[25] = 1'b1;
        1: begin instr[25] = 1'b0; instr[4] = 1'b0; end
        default: begin
          instr[25] = 1'b0;
          instr[4]  = 1'b1;
          rf[instr[11:8]] = rand_rs();
        end
      endcase
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      send(instr, rm);
    end
    rdy_mode = 1;
    wait_drain();
    chk("rs_pulse_count", rs_pulses, n_regsh);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
